// File: rtl/ifetch.sv
// rtl/ifetch.sv - instruction fetch unit with prefetch FIFO
// Single-outstanding imem port; jumps flush the FIFO and redirect the fetch PC.
module ifetch #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_out,
  output logic [15:0] imem_addr_out,
  input  logic        imem_ack_in,
  input  logic [15:0] imem_data_in,
  input  logic        ins_ready_in,
  output logic        il_out,
  output logic [15:0] ins_out,
  output logic [15:0] pc_out,
  input  logic        jump_in,
  input  logic [15:0] jump_addr_in
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, REQ, FLUSH} state_t;

  state_t        r_state, w_state_next;
  logic          r_req;
  logic [15:0]   r_addr, w_addr_next;
  logic [15:0]   r_pc, w_pc_next;
  logic [15:0]   r_fifo_addr [FIFO_DEPTH];
  logic [15:0]   r_fifo_data [FIFO_DEPTH];
  logic [PW-1:0] r_rd_ptr, r_wr_ptr;
  logic [CW-1:0] r_count, w_count_next;
  logic          w_empty, w_ack, w_push, w_pop, w_busy_after;

  assign w_empty      = (r_count == '0);
  assign w_ack        = r_req && imem_ack_in;
  // Acks in FLUSH, or coincident with a jump, belong to a stale stream.
  assign w_push       = w_ack && (r_state == REQ) && !jump_in;
  assign w_pop        = !w_empty && ins_ready_in && !jump_in;
  assign w_busy_after = r_req && !imem_ack_in;

  assign il_out        = w_pop;
  assign ins_out       = w_empty ? 16'h0000 : r_fifo_data[r_rd_ptr];
  assign pc_out        = w_empty ? 16'h0000 : r_fifo_addr[r_rd_ptr];
  assign imem_req_out  = r_req;
  assign imem_addr_out = r_addr;

  always_comb begin
    w_count_next = r_count;
    if (jump_in)
      w_count_next = '0;
    else if (w_push && !w_pop)
      w_count_next = r_count + CW'(1);
    else if (!w_push && w_pop)
      w_count_next = r_count - CW'(1);
  end

  always_comb begin
    w_state_next = r_state;
    w_addr_next  = r_addr;
    w_pc_next    = r_pc;
    if (jump_in)
      w_pc_next = jump_addr_in;
    else if (w_push)
      w_pc_next = r_addr + 16'd1;

    if (w_busy_after) begin
      // Request still in flight: req/addr hold, a jump turns it stale.
      w_state_next = (jump_in || r_state == FLUSH) ? FLUSH : REQ;
    end else if (w_count_next < DEPTH_C) begin
      w_state_next = REQ;
      w_addr_next  = w_pc_next;
    end else begin
      w_state_next = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_req    <= 1'b0;
      r_addr   <= RESET_PC;
      r_pc     <= RESET_PC;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_state <= w_state_next;
      r_req   <= (w_state_next != IDLE);
      r_addr  <= w_addr_next;
      r_pc    <= w_pc_next;
      r_count <= w_count_next;
      if (jump_in) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_push)
          r_wr_ptr <= (r_wr_ptr == LAST_C) ? '0 : r_wr_ptr + PW'(1);
        if (w_pop)
          r_rd_ptr <= (r_rd_ptr == LAST_C) ? '0 : r_rd_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= r_addr;
      r_fifo_data[r_wr_ptr] <= imem_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)
      assert (!(w_push && r_count == DEPTH_C));
  end
endmodule

// File: tb/tb_ifetch.sv
// tb/tb_ifetch.sv - scoreboard bench for ifetch
// Expected fetch stream is sequential from the last reset/jump target.
module tb_ifetch;
  localparam logic [15:0] RESET_PC   = 16'h0000;
  localparam int          FIFO_DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_out;
  logic [15:0] imem_addr_out;
  logic        imem_ack_in;
  logic [15:0] imem_data_in;
  logic        ins_ready_in;
  logic        il_out;
  logic [15:0] ins_out;
  logic [15:0] pc_out;
  logic        jump_in;
  logic [15:0] jump_addr_in;

  ifetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_out(imem_req_out), .imem_addr_out(imem_addr_out),
    .imem_ack_in(imem_ack_in), .imem_data_in(imem_data_in),
    .ins_ready_in(ins_ready_in), .il_out(il_out),
    .ins_out(ins_out), .pc_out(pc_out),
    .jump_in(jump_in), .jump_addr_in(jump_addr_in)
  );

  always #5 clk = ~clk;

  int          n_err = 0;
  int          n_checks = 0;
  logic [31:0] exp_q [$];
  logic [15:0] nxt_pc;
  int          wait_mode = 0;
  bit          stray_en = 0;
  bit          force_stray = 0;
  int          n_push, n_pop, total_pops = 0;
  bit          saw_wrap;
  logic [15:0] prev_pop_pc;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic topup();
    logic [15:0] d;
    while (exp_q.size() < 16) begin
      d = 16'hA000 + nxt_pc;
      exp_q.push_back({nxt_pc, d});
      nxt_pc = nxt_pc + 16'd1;
    end
  endtask

  task automatic step(input logic rdy, input logic j, input logic [15:0] t);
    @(posedge clk); #1;
    force_stray  = 0;
    ins_ready_in = rdy;
    jump_in      = j;
    jump_addr_in = t;
    if (j) begin
      exp_q.delete();
      nxt_pc = t;
    end
    topup();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    jump_in = 1'b0;
    exp_q.delete();
    nxt_pc = RESET_PC;
    @(posedge clk); #1;
    rst = 1'b0;
    topup();
  endtask

  // Memory responder: configurable wait states, optional stray acks.
  initial begin : responder
    bit busy;
    int left;
    busy = 0;
    left = 0;
    imem_ack_in  = 1'b0;
    imem_data_in = 16'h0000;
    forever begin
      @(posedge clk); #2;
      if (rst) begin
        busy = 0;
        imem_ack_in = 1'b0;
      end else if (imem_req_out) begin
        if (!busy) begin
          busy = 1;
          left = (wait_mode < 0) ? int'($urandom_range(3, 0)) : wait_mode;
        end
        if (left == 0) begin
          imem_ack_in  = 1'b1;
          imem_data_in = 16'hA000 + imem_addr_out;
          busy = 0;
        end else begin
          imem_ack_in = 1'b0;
          left--;
        end
      end else begin
        busy = 0;
        imem_ack_in  = force_stray || (stray_en && $urandom_range(7, 0) == 0);
        imem_data_in = 16'($urandom);
      end
    end
  end

  // Monitor: request-sequence checks and scoreboard pops.
  initial begin : monitor
    bit          prev_busy, stale;
    logic [15:0] exp_req, cur_addr;
    logic [31:0] e;
    prev_busy = 0; stale = 0; exp_req = RESET_PC; cur_addr = RESET_PC;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_busy = 0; stale = 0; exp_req = RESET_PC;
        n_push = 0; n_pop = 0; saw_wrap = 0; prev_pop_pc = 16'h0000;
      end else begin
        if (imem_req_out) begin
          if (!prev_busy) begin
            check("req_addr", 32'(imem_addr_out), 32'(exp_req));
            cur_addr = imem_addr_out;
            stale = 0;
          end else begin
            check("req_addr_stable", 32'(imem_addr_out), 32'(cur_addr));
          end
        end
        if (jump_in) begin
          check("il_in_jump", 32'(il_out), 32'd0);
          exp_req = jump_addr_in;
          if (imem_req_out && !imem_ack_in) stale = 1;
        end else if (imem_req_out && imem_ack_in && !stale) begin
          exp_req = imem_addr_out + 16'd1;
          n_push++;
        end
        prev_busy = imem_req_out && !imem_ack_in;
        if (il_out) begin
          n_pop++;
          total_pops++;
          if (exp_q.size() == 0) begin
            n_checks++; n_err++;
            $display("FAIL scoreboard_empty: got pc %h expected none", pc_out);
          end else begin
            e = exp_q.pop_front();
            check("pop_pc_ins", {pc_out, ins_out}, e);
          end
          if (pc_out == 16'h0000 && prev_pop_pc == 16'hFFFF) saw_wrap = 1;
          prev_pop_pc = pc_out;
        end else if (ins_ready_in && !jump_in) begin
          check("empty_outputs", {pc_out, ins_out}, 32'd0);
        end
      end
    end
  end

  initial begin : stimulus
    bit found;
    rst = 1'b1; ins_ready_in = 1'b1; jump_in = 1'b0; jump_addr_in = 16'h0000;
    nxt_pc = RESET_PC;

    @(posedge clk); #1;
    check("rst_req", 32'(imem_req_out), 32'd0);
    check("rst_addr", 32'(imem_addr_out), 32'(RESET_PC));
    check("rst_il", 32'(il_out), 32'd0);
    check("rst_ins", 32'(ins_out), 32'd0);
    check("rst_pc", 32'(pc_out), 32'd0);

    // Zero-wait streaming from reset.
    wait_mode = 0;
    @(posedge clk); #1;
    rst = 1'b0; topup();
    step(1, 0, 0);
    check("c1_req", 32'(imem_req_out), 32'd1);
    check("c1_addr", 32'(imem_addr_out), 32'(RESET_PC));
    step(1, 0, 0);
    check("c2_il", 32'(il_out), 32'd1);
    check("c2_pc_ins", {pc_out, ins_out}, {RESET_PC, 16'hA000 + RESET_PC});
    repeat (20) step(1, 0, 0);

    // Three wait states.
    wait_mode = 3;
    repeat (40) step(1, 0, 0);

    // Stall: FIFO fills to depth, then request stops.
    wait_mode = 0;
    do_reset();
    repeat (10) step(0, 0, 0);
    check("stall_buffered", 32'(n_push - n_pop), 32'(FIFO_DEPTH));
    check("stall_req_low", 32'(imem_req_out), 32'd0);
    repeat (10) step(1, 0, 0);

    // Jump while a waited request to 5 is outstanding.
    wait_mode = 2;
    do_reset();
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      step(1, 0, 0);
      if (imem_req_out && imem_addr_out == 16'd5) found = 1;
    end
    check("reach_addr5", 32'(found), 32'd1);
    step(1, 1, 16'h0400);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1, 0, 0);
      if (imem_req_out && imem_addr_out != 16'd5) found = 1;
    end
    check("jump_req_addr", 32'(imem_addr_out), 32'h0400);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1, 0, 0);
      if (il_out) found = 1;
    end
    check("jump_first_pc", 32'(pc_out), 32'h0400);

    // Jumps coincident with ack and pop in zero-wait streaming.
    wait_mode = 0;
    repeat (5) step(1, 0, 0);
    step(1, 1, 16'h1234);
    repeat (5) step(1, 0, 0);
    step(1, 1, 16'h2000);
    step(1, 1, 16'h3000);
    repeat (5) step(1, 0, 0);

    // Random traffic.
    wait_mode = -1;
    stray_en = 1;
    for (int i = 0; i < 1500; i++)
      step($urandom_range(3, 0) != 0, $urandom_range(11, 0) == 0,
           $urandom_range(1, 0) ? 16'hFFFE : 16'($urandom));
    stray_en = 0;

    // Address wrap.
    wait_mode = 0;
    do_reset();
    step(1, 1, 16'hFFFE);
    repeat (8) step(1, 0, 0);
    check("wrap_seen", 32'(saw_wrap), 32'd1);

    // Reset with a request outstanding, then a late ack.
    wait_mode = 3;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1, 0, 0);
      if (imem_req_out) found = 1;
    end
    check("mid_req_seen", 32'(found), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    nxt_pc = RESET_PC;
    @(posedge clk); #1;
    check("midrst_req", 32'(imem_req_out), 32'd0);
    check("midrst_il_pc_ins", {15'd0, il_out, pc_out}, 32'd0);
    check("midrst_ins", 32'(ins_out), 32'd0);
    rst = 1'b0; force_stray = 1; topup();
    wait_mode = 0;
    step(1, 0, 0);
    check("restart_addr", {15'd0, imem_req_out, imem_addr_out}, {15'd0, 1'b1, RESET_PC});
    repeat (20) step(1, 0, 0);

    check("pops_seen", 32'(total_pops > 200), 32'd1);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
